rr_mux_sel_arbiter: RTL and testbench
=====================================

Name: rr_mux_sel_arbiter

Overview:
- Four-requester round-robin arbiter that sits directly upstream of the 4-to-1 multiplexer.
- Drives the mux select (sel[1:0]) and a one-hot grant back to the requesters.
- Holds each grant until the owner releases it, drops its request, or a hold timeout expires.
- Ensures fair, glitch-free channel selection for the downstream mux.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles a grant is held. 0 disables the timeout. Legal range 0..255.

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  arbitration enable; gates new grants only
- req  input  4  per-channel request, level-sensitive
- release_i  input  1  owner done; ends current grant
- grant  output  4  registered one-hot grant
- sel  output  2  registered binary index of granted channel; feeds mux sel
- grant_valid  output  1  high while any grant is active
- timeout  output  1  single-cycle pulse when a grant is revoked by MAX_HOLD

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n). Reset clears immediately, with no clock edge needed.
- Reset values: grant=0000, sel=00, grant_valid=0, timeout=0, priority pointer ptr=0, hold counter=0, state=IDLE.
- Internal state: 2-state FSM (IDLE, GRANT), 2-bit ptr, 8-bit hold counter.
- IDLE:
  - If en=1 and req!=0, pick the first set req bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - On the next edge: grant=onehot(idx), sel=idx, grant_valid=1, hold=0, state=GRANT.
  - Latency is 1 cycle from sampled request to grant.
- IDLE with en=0 or req=0: outputs unchanged. sel keeps its last value so the mux output stays stable. grant=0, grant_valid=0.
- GRANT: hold increments every cycle. The grant ends on the edge where any of these is true:
  - (a) release_i=1
  - (b) req[sel]=0
  - (c) MAX_HOLD!=0 and hold==MAX_HOLD-1
- On grant end, next edge: grant=0000, grant_valid=0, ptr=sel+1 (wraps 3->0), hold=0, state=IDLE. sel is unchanged.
- Grant lengths:
  - With no early release, grant_valid stays high exactly MAX_HOLD cycles.
  - The minimum grant is 1 cycle (release_i high in the first grant cycle).
- Mandatory idle bubble: at least 1 cycle with grant_valid=0 between consecutive grants, even to the same channel.
- timeout:
  - Asserted for exactly 1 cycle, coincident with the first cycle grant_valid=0.
  - Only asserted if (c) is the sole cause. If release_i=1 or req[sel]=0 on the same cycle, the end counts as a normal release and timeout=0.
- While in GRANT:
  - en=0 does not revoke the current grant.
  - Requests from other channels are ignored until IDLE.
- Invariants: grant is always one-hot or zero. grant!=0 iff grant_valid=1. When grant_valid=1, sel equals the index of the set grant bit.
- Reset asserted mid-grant: all outputs and state return to reset values asynchronously. The first arbitration after deassertion starts from ptr=0.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with req=1111 -> grant=0000, sel=00, grant_valid=0, timeout=0 immediately, no clock edge needed.
- Single request: req=0100 from cycle 0, release_i pulsed on the 3rd grant cycle -> grant=0100, sel=10 from cycle 1; grant_valid high 3 cycles, then 0; a later req=1001 is granted to ch3 (ptr=3).
- Fairness: req=1111 held, release_i pulsed on every 2nd grant cycle -> sel sequence 0,1,2,3,0; each grant lasts 2 cycles with a 1-cycle grant_valid=0 gap between grants.
- Timeout: MAX_HOLD=16, req=0010 held, release_i=0 -> grant=0010 for exactly 16 cycles; timeout=1 for 1 cycle; regrant ch1 after a 1-cycle bubble.
- Request drop: req[3] deasserted on the 5th cycle of its grant -> grant=0000 on the next edge, timeout=0, ptr=0.
- Enable gating: en=0 with req=0001 -> no grant for 10 cycles; raise en -> grant=0001 one cycle later; drop en during the grant -> grant is not revoked.

Source files
------------

// File: rtl/rr_mux_sel_arbiter_if.sv
// rtl/rr_mux_sel_arbiter_if.sv - request/grant bundle between requesters and the mux-select arbiter
interface rr_mux_sel_arbiter_if;
    logic       en;
    logic [3:0] req;
    logic       release_i;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       grant_valid;
    logic       timeout;

    // Requester side: drives requests, observes grant and mux select
    modport master (
        output en,
        output req,
        output release_i,
        input  grant,
        input  sel,
        input  grant_valid,
        input  timeout
    );

    // Arbiter side
    modport slave (
        input  en,
        input  req,
        input  release_i,
        output grant,
        output sel,
        output grant_valid,
        output timeout
    );
endinterface

// File: rtl/rr_mux_sel_arbiter.sv
// rtl/rr_mux_sel_arbiter.sv - four-way round-robin arbiter driving a 4:1 mux select with hold timeout
module rr_mux_sel_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rr_mux_sel_arbiter_if.slave  arb
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Hold count on the last permitted grant cycle; MAX_HOLD of 0 turns the limit off
    localparam bit         TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST  = TIMEOUT_EN ? 8'(MAX_HOLD - 1) : 8'd0;

    state_t     state;
    logic [1:0] ptr;
    logic [7:0] hold;

    logic       pick_found;
    logic [1:0] pick_idx;
    logic       rel_end;
    logic       hold_end;

    // Round-robin pick: nearest requester at or after ptr wins (scan from farthest so nearest overwrites)
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr;
        for (int i = 3; i >= 0; i--) begin
            if (arb.req[ptr + 2'(i)]) begin
                pick_found = 1'b1;
                pick_idx   = ptr + 2'(i);
            end
        end
    end

    // Grant termination causes; a voluntary end masks a coincident hold expiry
    always_comb begin
        rel_end  = arb.release_i | ~arb.req[arb.sel];
        hold_end = TIMEOUT_EN && (hold == HOLD_LAST);
    end

    // Arbiter FSM with registered grant, select and timeout outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            ptr             <= 2'd0;
            hold            <= 8'd0;
            arb.grant       <= 4'b0000;
            arb.sel         <= 2'd0;
            arb.grant_valid <= 1'b0;
            arb.timeout     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    arb.timeout <= 1'b0;
                    if (arb.en && pick_found) begin
                        arb.grant       <= 4'b0001 << pick_idx;
                        arb.sel         <= pick_idx;
                        arb.grant_valid <= 1'b1;
                        hold            <= 8'd0;
                        state           <= GRANT;
                    end else begin
                        // sel is left alone so the downstream mux output stays put while idle
                        arb.grant       <= 4'b0000;
                        arb.grant_valid <= 1'b0;
                    end
                end
                GRANT: begin
                    if (rel_end || hold_end) begin
                        arb.grant       <= 4'b0000;
                        arb.grant_valid <= 1'b0;
                        arb.timeout     <= hold_end && !rel_end;
                        ptr             <= arb.sel + 2'd1;
                        hold            <= 8'd0;
                        state           <= IDLE;
                    end else begin
                        hold <= hold + 8'd1;
                    end
                end
                default: begin
                    state           <= IDLE;
                    arb.grant       <= 4'b0000;
                    arb.grant_valid <= 1'b0;
                    arb.timeout     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mux_sel_arbiter.sv
// tb/tb_rr_mux_sel_arbiter.sv - scoreboard bench for the round-robin mux-select arbiter
module tb_rr_mux_sel_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    rr_mux_sel_arbiter_if ifc();

    rr_mux_sel_arbiter #(.MAX_HOLD(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (ifc)
    );

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] sel;
        logic       gv;
        logic       to;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic exp_t mk(input logic [3:0] g, input logic [1:0] s, input logic v, input logic t);
        exp_t x;
        x.grant = g;
        x.sel   = s;
        x.gv    = v;
        x.to    = t;
        return x;
    endfunction

    function automatic exp_t observed();
        exp_t x;
        x.grant = ifc.grant;
        x.sel   = ifc.sel;
        x.gv    = ifc.grant_valid;
        x.to    = ifc.timeout;
        return x;
    endfunction

    function automatic string fmt(input exp_t x);
        return $sformatf("grant=%b sel=%0d gv=%b to=%b", x.grant, x.sel, x.gv, x.to);
    endfunction

    function automatic logic [3:0] onehot(input int idx);
        logic [3:0] v;
        v = 4'b0001 << idx;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n         = 1'b0;
        ifc.en        = 1'b0;
        ifc.req       = 4'b0000;
        ifc.release_i = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e, o;
        exp_t tbl [3];
        logic rel_tbl [3];
        rst_n         = 1'b0;
        ifc.en        = 1'b0;
        ifc.req       = 4'b0000;
        ifc.release_i = 1'b0;
        tick();
        tick();
        sb.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0));
        e = sb.pop_front();
        o = observed();
        n_chk++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_hold: got %s want %s", fmt(o), fmt(e));
        end
        rst_n   = 1'b1;
        ifc.en  = 1'b1;
        ifc.req = 4'b1111;
        tbl[0] = mk(4'b0001, 2'd0, 1'b1, 1'b0); rel_tbl[0] = 1'b0;
        tbl[1] = mk(4'b0000, 2'd0, 1'b0, 1'b0); rel_tbl[1] = 1'b1;
        tbl[2] = mk(4'b0010, 2'd1, 1'b1, 1'b0); rel_tbl[2] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            ifc.release_i = rel_tbl[c];
            sb.push_back(tbl[c]);
            tick();
            e = sb.pop_front();
            o = observed();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_pre c%0d: got %s want %s", c, fmt(o), fmt(e));
            end
        end
        #3;
        rst_n = 1'b0;
        sb.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0));
        #1;
        e = sb.pop_front();
        o = observed();
        n_chk++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL async_reset: got %s want %s", fmt(o), fmt(e));
        end
        tick();
        rst_n = 1'b1;
        sb.push_back(mk(4'b0001, 2'd0, 1'b1, 1'b0));
        tick();
        e = sb.pop_front();
        o = observed();
        n_chk++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_ptr0: got %s want %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_single();
        exp_t e, o;
        apply_reset();
        ifc.en = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            ifc.release_i = (c == 4);
            ifc.req       = (c == 5) ? 4'b1001 : 4'b0100;
            if (c <= 3)      sb.push_back(mk(4'b0100, 2'd2, 1'b1, 1'b0));
            else if (c == 4) sb.push_back(mk(4'b0000, 2'd2, 1'b0, 1'b0));
            else             sb.push_back(mk(4'b1000, 2'd3, 1'b1, 1'b0));
            tick();
            e = sb.pop_front();
            o = observed();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL single c%0d: got %s want %s", c, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_fairness();
        exp_t e, o;
        apply_reset();
        ifc.en  = 1'b1;
        ifc.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            for (int p = 0; p < 3; p++) begin
                ifc.release_i = (p == 2);
                if (p < 2) sb.push_back(mk(onehot(g % 4), 2'(g % 4), 1'b1, 1'b0));
                else       sb.push_back(mk(4'b0000, 2'(g % 4), 1'b0, 1'b0));
                tick();
                e = sb.pop_front();
                o = observed();
                n_chk++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL fairness g%0d p%0d: got %s want %s", g, p, fmt(o), fmt(e));
                end
            end
        end
        ifc.release_i = 1'b0;
    endtask

    task automatic test_timeout();
        exp_t e, o;
        apply_reset();
        ifc.en        = 1'b1;
        ifc.req       = 4'b0010;
        ifc.release_i = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            if (c == 17) sb.push_back(mk(4'b0000, 2'd1, 1'b0, 1'b1));
            else         sb.push_back(mk(4'b0010, 2'd1, 1'b1, 1'b0));
            tick();
            e = sb.pop_front();
            o = observed();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL timeout c%0d: got %s want %s", c, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_req_drop();
        exp_t e, o;
        apply_reset();
        ifc.en        = 1'b1;
        ifc.release_i = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            ifc.req = (c <= 5) ? 4'b1000 : ((c == 6) ? 4'b0000 : 4'b1111);
            if (c <= 5)      sb.push_back(mk(4'b1000, 2'd3, 1'b1, 1'b0));
            else if (c == 6) sb.push_back(mk(4'b0000, 2'd3, 1'b0, 1'b0));
            else             sb.push_back(mk(4'b0001, 2'd0, 1'b1, 1'b0));
            tick();
            e = sb.pop_front();
            o = observed();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL req_drop c%0d: got %s want %s", c, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_enable();
        exp_t e, o;
        apply_reset();
        ifc.req = 4'b0001;
        for (int c = 1; c <= 17; c++) begin
            ifc.en        = (c == 11);
            ifc.release_i = (c == 15);
            if (c >= 11 && c <= 14) sb.push_back(mk(4'b0001, 2'd0, 1'b1, 1'b0));
            else                    sb.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0));
            tick();
            e = sb.pop_front();
            o = observed();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL enable c%0d: got %s want %s", c, fmt(o), fmt(e));
            end
        end
        ifc.release_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        ifc.en        = 1'b0;
        ifc.req       = 4'b0000;
        ifc.release_i = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_timeout();
        test_req_drop();
        test_enable();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
